// File: rtl/bcd_sub_sequencer_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef logic [3:0] digit_t;

   localparam digit_t     BCD_MAX  = 4'd9;
   localparam logic [4:0] BCD_BASE = 5'd10;

   function automatic logic digit_invalid(input digit_t d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_sub_sequencer_if.sv
// Operand/result handshake bundle for bcd_sub_sequencer.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both 1; the sender holds its data stable until then.
interface bcd_sub_sequencer_if #(
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   x_bcd;
   logic [4*DIGITS-1:0]   y_bcd;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   diff_bcd;
   logic                  sign;
   logic                  err;

   modport master (
      output in_valid, x_bcd, y_bcd, out_ready,
      input  in_ready, out_valid, diff_bcd, sign, err
   );

   modport slave (
      input  in_valid, x_bcd, y_bcd, out_ready,
      output in_ready, out_valid, diff_bcd, sign, err
   );
endinterface

// File: rtl/bcd_sub_sequencer_digit_sub.sv
// One BCD digit subtract slice: d = a - b - borrow_in, corrected by +10 on underflow.
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  digit_t a,
   input  digit_t b,
   input  logic   borrow_in,
   output digit_t d,
   output logic   borrow_out
);
   logic [4:0] raw;
   logic [4:0] corrected;

   always_comb begin
      raw        = {1'b0, a} - {1'b0, b} - {4'b0000, borrow_in};
      corrected  = raw + BCD_BASE;
      borrow_out = raw[4];
      d          = borrow_out ? corrected[3:0] : raw[3:0];
   end
endmodule

// File: rtl/bcd_sub_sequencer.sv
// Digit-serial BCD subtractor: y - x, ones digit first, with a ten's-complement pass for negatives.
// Optional build macro BCD_SUB_DIGIT_CHECK_EN flags operand digits above 9 on err.
module bcd_sub_sequencer
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3
)(
   input  logic                clk,
   input  logic                rst_n,
   bcd_sub_sequencer_if.slave  bus,
   output state_t              state_dbg
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            borrow;
   logic [W-1:0]    x_q, y_q, raw_q, next_raw;
   logic [W-1:0]    diff_q;
   logic            sign_q, err_q, in_ready_q, out_valid_q;
   logic            last_digit, bad;
   digit_t          a_dig, b_dig, d_dig;
   logic            borrow_out;

   assign last_digit = (cnt == CW'(DIGITS - 1));

   // The single slice is shared: SUB feeds y_k/x_k, NEG feeds 0/raw_k.
   always_comb begin
      a_dig = y_q[{cnt, 2'b00} +: 4];
      b_dig = x_q[{cnt, 2'b00} +: 4];
      if (state == NEG) begin
         a_dig = '0;
         b_dig = raw_q[{cnt, 2'b00} +: 4];
      end
   end

   bcd_digit_sub u_slice (
      .a          (a_dig),
      .b          (b_dig),
      .borrow_in  (borrow),
      .d          (d_dig),
      .borrow_out (borrow_out)
   );

   always_comb begin
      next_raw = raw_q;
      next_raw[{cnt, 2'b00} +: 4] = d_dig;
   end

`ifdef BCD_SUB_DIGIT_CHECK_EN
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | digit_invalid(x_q[4*i +: 4]) | digit_invalid(y_q[4*i +: 4]);
      end
   end
`else
   assign bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt         <= '0;
         borrow      <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         raw_q       <= '0;
         diff_q      <= '0;
         sign_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_q        <= bus.x_bcd;
                  y_q        <= bus.y_bcd;
                  cnt        <= '0;
                  borrow     <= 1'b0;
                  in_ready_q <= 1'b0;
                  state      <= SUB;
               end
            end
            SUB: begin
               raw_q  <= next_raw;
               borrow <= borrow_out;
               if (last_digit) begin
                  cnt <= '0;
                  if (borrow_out) begin
                     borrow <= 1'b0;
                     state  <= NEG;
                  end else begin
                     out_valid_q <= 1'b1;
                     diff_q      <= bad ? '0 : next_raw;
                     sign_q      <= 1'b0;
                     err_q       <= bad;
                     state       <= DONE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            NEG: begin
               // raw_q is rewritten in place with its ten's complement.
               raw_q  <= next_raw;
               borrow <= borrow_out;
               if (last_digit) begin
                  cnt         <= '0;
                  borrow      <= 1'b0;
                  out_valid_q <= 1'b1;
                  diff_q      <= bad ? '0 : next_raw;
                  sign_q      <= ~bad;
                  err_q       <= bad;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.diff_bcd  = diff_q;
   assign bus.sign      = sign_q;
   assign bus.err       = err_q;
   assign state_dbg     = state;
endmodule

// File: doc/bcd_sub_sequencer.md
BCD_SUB_SEQUENCER -- requirements
Module: bcd_sub_sequencer

Interface
REQ-001 Parameter DIGITS, default 3: number of BCD digits per operand; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 x_bcd  input  4*DIGITS  subtrahend; digit 0 (ones) in bits 3:0.
REQ-007 y_bcd  input  4*DIGITS  minuend; same packing.
REQ-008 out_valid  output  1  result held stable.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 diff_bcd  output  4*DIGITS  magnitude of y - x, BCD, same packing.
REQ-011 sign  output  1  1 when y < x.
REQ-012 err  output  1  1 when any accepted operand digit exceeds 9.

Function
REQ-013 The block SHALL compute y_bcd - x_bcd digit-serially, one digit per clock, ones digit first, on one shared digit slice.
REQ-014 States SHALL be IDLE, SUB, NEG, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge with in_valid & in_ready, latching both operands, clearing borrow and the digit counter, and entering SUB.
REQ-016 SUB SHALL process digit k = y_k - x_k - borrow, add 10 on underflow, store result digit k and update borrow; it SHALL leave after DIGITS clocks.
REQ-017 If the final SUB borrow is 0, the block SHALL enter DONE with sign=0; otherwise it SHALL enter NEG.
REQ-018 NEG SHALL compute 0 - raw result digit-serially over DIGITS clocks (ten's-complement magnitude), then enter DONE with sign=1.
REQ-019 Latency SHALL be DIGITS clocks (non-negative) or 2*DIGITS clocks (negative) from the accepting edge to out_valid=1; with DIGITS=3, out_valid is first seen after the 3rd or 6th edge respectively.
REQ-020 In DONE, out_valid=1 and diff_bcd, sign and err SHALL remain stable until out_ready=1; on that edge the block SHALL return to IDLE.
REQ-021 No new operand pair SHALL be accepted in the same edge as a result transfer; in_ready rises one clock later.
REQ-022 A zero result SHALL always report sign=0.
REQ-023 diff_bcd, sign and err SHALL hold their last values outside DONE; out_valid SHALL be 0 outside DONE.

Reset
REQ-024 rst_n=0 SHALL force IDLE, in_ready=1, out_valid=0, diff_bcd=0, sign=0, err=0, borrow=0, digit counter=0 immediately, independent of clk.
REQ-025 Reset asserted in SUB, NEG or DONE SHALL abandon the operation; no result is delivered for it.

Configuration
REQ-026 With BCD_SUB_DIGIT_CHECK_EN defined, err SHALL be set in DONE if any latched x or y digit is above 9, and diff_bcd SHALL then be all zero with sign=0.
REQ-027 Without BCD_SUB_DIGIT_CHECK_EN, err SHALL be constant 0 and invalid digits SHALL pass through the slice arithmetic unchecked, giving a deterministic but unspecified result.

Structure
REQ-028 Package bcd_pkg SHALL hold the state enumeration, the 4-bit digit type and the constants BCD_MAX=9 and BCD_BASE=10.
REQ-029 The combinational sub-module bcd_digit_sub SHALL take (a, b, borrow_in) and return (d, borrow_out); it SHALL be instantiated once and shared by SUB and NEG.

Verification
REQ-030 y=523, x=100 -> after 3 edges out_valid=1, diff=423, sign=0, err=0.
REQ-031 y=100, x=523 -> after 6 edges out_valid=1, diff=423, sign=1.
REQ-032 y=000, x=000 and y=999, x=999 -> diff=000, sign=0; y=999, x=000 -> 999, sign=0; y=000, x=999 -> 999, sign=1.
REQ-033 Backpressure: out_ready held 0 for 5 clocks in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 on the next clock.
REQ-034 rst_n pulsed low mid-SUB on y=750, x=123 -> outputs at reset values at once; the next operation y=200, x=001 -> 199, sign=0.
REQ-035 With BCD_SUB_DIGIT_CHECK_EN: y=1A0 (hex digit A) -> err=1, diff=000; without the macro: err=0.
